// File: rtl/servo_pwm_axil_multi.sv
// Multi-channel servo PWM controller behind an AXI4-Lite slave.
// Software writes shadow PERIOD/PULSE registers; the active set reloads only at a period wrap or on enable.
module servo_pwm_axil_multi #(
  parameter int NUM_CH             = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int CLK_DIV            = 100,
  parameter int CNT_W              = 16,
  parameter int PERIOD_RST         = 20000,
  parameter int PULSE_RST          = 1500
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_CH-1:0]                 pwm_out,
  output logic                              period_irq
);
  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int IW   = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NREG = 2 ** IW;
  localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] period_q, period_d, per_act_q, per_act_d, cnt_q, cnt_d;
  logic [CNT_W-1:0] pulse_q [NUM_CH];
  logic [CNT_W-1:0] pulse_d [NUM_CH];
  logic [CNT_W-1:0] pul_act_q [NUM_CH];
  logic [CNT_W-1:0] pul_act_d [NUM_CH];
  logic             pending_q, pending_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic             irq_q, irq_d;
  logic             bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic [IW-1:0] wr_idx, rd_idx;
  logic          wr_en, rd_en, wr_ok, rd_ok, wr_shadow;
  logic [DW-1:0] regs_view [NREG];
  logic [DW-1:0] wr_word;
  logic          tick, wrap, en_rise, load;

  assign wr_idx    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_ok     = int'(wr_idx) < 4 + NUM_CH;
  assign rd_ok     = int'(rd_idx) < 4 + NUM_CH;
  assign wr_shadow = wr_ok && ((wr_idx == IW'(1)) || (int'(wr_idx) >= 4));
  assign wr_en     = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
  assign rd_en     = S_AXI_ARVALID && !rvalid_q;

  // Read view of the whole word-address space; undecoded words read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_view
      if (gi == 0) begin : g_ctrl
        assign regs_view[gi] = DW'(ctrl_q);
      end else if (gi == 1) begin : g_period
        assign regs_view[gi] = DW'(period_q);
      end else if (gi == 2) begin : g_status
        assign regs_view[gi] = {16'(cnt_q), 15'd0, pending_q};
      end else if (gi >= 4 && gi < 4 + NUM_CH) begin : g_pulse
        assign regs_view[gi] = DW'(pulse_q[gi-4]);
      end else begin : g_zero
        assign regs_view[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    wr_word = regs_view[wr_idx];
    for (int b = 0; b < DW / 8; b++) begin
      if (S_AXI_WSTRB[b]) wr_word[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    period_d = period_q;
    pulse_d  = pulse_q;
    if (wr_en) begin
      if (wr_idx == IW'(0)) ctrl_d = wr_word[1:0];
      if (wr_idx == IW'(1)) period_d = wr_word[CNT_W-1:0];
      for (int k = 0; k < NUM_CH; k++) begin
        if (int'(wr_idx) == 4 + k) pulse_d[k] = wr_word[CNT_W-1:0];
      end
    end
  end

  assign tick    = ctrl_q[0] && (presc_q == PW'(CLK_DIV - 1));
  assign wrap    = tick && (cnt_q == per_act_q - CNT_W'(1));
  assign en_rise = !ctrl_q[0] && ctrl_d[0];
  assign load    = wrap || en_rise;

  always_comb begin
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    per_act_d = per_act_q;
    pul_act_d = pul_act_q;
    pending_d = pending_q;
    if (!ctrl_q[0]) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
    // Loads sample the shadow values held before this cycle; a coincident write waits for the next wrap.
    if (load) begin
      per_act_d = (period_q < CNT_W'(2)) ? CNT_W'(2) : period_q;
      pul_act_d = pulse_q;
      pending_d = 1'b0;
    end
    if (wr_en && wr_shadow) pending_d = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      pwm_d[k] = ctrl_q[0] && (cnt_q < pul_act_q[k]);
    end
    irq_d = wrap && ctrl_q[1];
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (wr_en) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (rd_en) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = regs_view[rd_idx];
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_q    <= '0;
      period_q  <= CNT_W'(PERIOD_RST);
      per_act_q <= CNT_W'(PERIOD_RST);
      for (int k = 0; k < NUM_CH; k++) begin
        pulse_q[k]   <= CNT_W'(PULSE_RST);
        pul_act_q[k] <= CNT_W'(PULSE_RST);
      end
      cnt_q     <= '0;
      presc_q   <= '0;
      pending_q <= 1'b0;
      pwm_q     <= '0;
      irq_q     <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      period_q  <= period_d;
      per_act_q <= per_act_d;
      pulse_q   <= pulse_d;
      pul_act_q <= pul_act_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      irq_q     <= irq_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = wr_en;
  assign S_AXI_WREADY  = wr_en;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = rd_en;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign pwm_out       = pwm_q;
  assign period_irq    = irq_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wr_word};
endmodule

// File: doc/servo_pwm_axil_multi.md
Name: servo_pwm_axil_multi

Overview:
Parametrised successor to the single-register servo controller IP. It is an AXI4-Lite slave that drives NUM_CH servo PWM outputs from one shared prescaled period counter. Per-channel pulse widths are double-buffered: software writes shadow registers, and the active set loads only at a period boundary, so outputs never glitch. The block sits behind the PS AXI interconnect; its outputs go to the servo pins.

Parameters:
NUM_CH, 8, number of PWM channels (1..16)
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
C_S_AXI_ADDR_WIDTH, 7, AXI byte-address width (covers 0x00..0x7C)
CLK_DIV, 100, ACLK cycles per PWM tick (>=1; 100 gives 1 us at 100 MHz)
CNT_W, 16, width of the period counter and pulse registers
PERIOD_RST, 20000, PERIOD reset value in ticks
PULSE_RST, 1500, reset value of each PULSE shadow register in ticks

Ports:
ACLK  in  1  sole clock
ARESETN  in  1  asynchronous, active-low reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  C_S_AXI_ADDR_WIDTH/3/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  C_S_AXI_ADDR_WIDTH/3/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
pwm_out  out  NUM_CH  registered PWM outputs
period_irq  out  1  one-cycle pulse at each period wrap

Behaviour:
- Register map (word-aligned, addr[1:0] ignored): 0x00 CTRL; 0x04 PERIOD; 0x08 STATUS (read-only); 0x0C reserved (reads 0, writes ignored, OKAY); 0x10+4k PULSE[k] for k<NUM_CH.
- CTRL: bit0 EN; bit1 IRQ_EN; other bits read 0.
- PERIOD: [CNT_W-1:0], shadow.
- PULSE[k]: [CNT_W-1:0], shadow.
- STATUS: bit0 PENDING (set on any PERIOD/PULSE write, cleared by a load); [31:16] current period count, zero-extended.
- WSTRB: byte-granular on all writable registers.
- Address decoding: any address >= 0x10+4*NUM_CH gets SLVERR on read (RDATA=0) and on write (no effect). All other addresses return OKAY.
- AXI write: AWREADY and WREADY assert together for one cycle only when AWVALID && WVALID && !BVALID. The register updates in that cycle. BVALID asserts the next cycle and holds until BREADY. One transaction is outstanding at a time.
- AXI read: ARREADY pulses for one cycle when ARVALID && !RVALID. RVALID and RDATA are registered the next cycle and held until RREADY.
- Reset values: all READY/VALID signals 0; RDATA 0; BRESP/RRESP 0; CTRL 0; PERIOD=PERIOD_RST; PULSE=PULSE_RST; active set = shadow reset values; prescaler 0; cnt 0; pwm_out 0; period_irq 0; PENDING 0.
- Prescaler: counts 0..CLK_DIV-1 while EN=1. tick=1 when the prescaler equals CLK_DIV-1.
- Period counter: cnt advances on tick. wrap = tick && cnt==per_act-1; on wrap, cnt goes to 0.
- Load: on wrap, per_act gets max(PERIOD,2) and each pul_act[k] gets PULSE[k]; PENDING clears. The shadow value used is the one registered before this cycle. A write landing in the same cycle keeps PENDING=1 and takes effect at the next wrap.
- EN 0->1 write: the same cycle clears the prescaler and cnt and performs a load.
- EN=0: prescaler and cnt are held at 0; pwm_out is 0 from the next cycle.
- pwm_out[k] is registered: pwm_out[k] <= EN && (cnt < pul_act[k]). Latency is 1 cycle after the cnt change.
- Pulse boundaries: pulse=0 gives constant low; pulse >= per_act gives constant high.
- period_irq <= wrap && IRQ_EN; it is a single ACLK cycle wide.
- ARESETN deasserted mid-period: everything returns to reset values immediately (asynchronous), including any in-flight AXI response being dropped.

Test Plan:
- Reset: ARESETN low 200 ns -> read 0x04=0x4E20, 0x10=0x5DC, 0x00=0, 0x08=0; pwm_out=0; all responses OKAY.
- Bench params CLK_DIV=2, NUM_CH=4. Write PERIOD=10, PULSE0..3={0,3,10,12}, then CTRL=3 -> pwm0 always 0; pwm1 high 6 of every 20 cycles; pwm2 and pwm3 always high; period_irq pulses every 20 cycles.
- While running, write PULSE1=5 at cnt=2 -> STATUS bit0=1; pwm1 width stays 6 cycles until the wrap, then becomes 10 cycles; bit0 returns to 0 after the wrap.
- Write PULSE1 in exactly the wrap cycle -> the old value is loaded; PENDING stays 1; the new width applies one period later.
- Write 0x20 -> BRESP=SLVERR; read 0x20 -> RRESP=SLVERR, RDATA=0. Write WSTRB=0x1 data 0xFFFF to 0x10 -> read 0x10 returns 0x00FF.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and RDATA stay stable, and no new AW/AR is accepted. Assert ARESETN low mid-period -> pwm_out=0 and cnt=0 in the same cycle.
